// File: rtl/mvm_accum.sv
// Output-lane accumulator: sums framed signed partial products and queues row results in an FWFT FIFO.
// Define ACCUM_SAT_EN to saturate on signed overflow (and drive sat_flag); otherwise adds wrap.
module mvm_accum #(
  parameter int IWIDTH     = 24,
  parameter int OWIDTH     = 32,
  parameter int ROWW       = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          pvalid,
  input  logic [IWIDTH-1:0]             pdata,
  input  logic                          pfirst,
  input  logic                          plast,
  output logic                          ovalid,
  output logic [OWIDTH-1:0]             odata,
  output logic [ROWW-1:0]               orow,
  input  logic                          oready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          err_ovf,
  output logic                          sat_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [OWIDTH-1:0] acc;
  logic [OWIDTH-1:0] base;
  logic [OWIDTH-1:0] raw;
  logic [OWIDTH-1:0] sum;
  logic [OWIDTH-1:0] pdata_ext;
  logic [ROWW-1:0]   row_idx;

  logic [OWIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [ROWW-1:0]   mem_row  [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic empty;
  logic full;
  logic push_req;
  logic do_push;
  logic do_pop;
  logic drop;

  assign pdata_ext = OWIDTH'($signed(pdata));

`ifdef ACCUM_SAT_EN
  logic sat_hit;
`endif

  always_comb begin
    base = pfirst ? '0 : acc;
    raw  = base + pdata_ext;
`ifdef ACCUM_SAT_EN
    // Overflow only when both operands share a sign that the result lost
    sat_hit = (base[OWIDTH-1] == pdata_ext[OWIDTH-1]) && (raw[OWIDTH-1] != base[OWIDTH-1]);
    if (sat_hit)
      sum = base[OWIDTH-1] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
    else
      sum = raw;
`else
    sum = raw;
`endif
  end

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign push_req = pvalid && plast && !clr;
  assign do_pop   = !empty && oready && !clr;
  assign do_push  = push_req && (!full || do_pop);
  assign drop     = push_req && full && !do_pop;

  assign ovalid   = !empty;
  assign odata    = empty ? '0 : mem_data[rd_ptr];
  assign orow     = empty ? '0 : mem_row[rd_ptr];
  assign fifo_cnt = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      row_idx <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      row_idx <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (pvalid) begin
        if (plast) begin
          acc     <= '0;
          row_idx <= row_idx + 1'b1;
        end else begin
          acc <= sum;
        end
      end
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (!do_push && do_pop)
        count <= count - 1'b1;
      if (drop)
        err_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= sum;
      mem_row[wr_ptr]  <= row_idx;
    end
  end

`ifdef ACCUM_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_flag <= 1'b0;
    else if (clr)
      sat_flag <= 1'b0;
    else if (pvalid && sat_hit)
      sat_flag <= 1'b1;
  end
`else
  assign sat_flag = 1'b0;
`endif

endmodule
